// File: rtl/stripe_lane_scheduler.sv
// -----------------------------------------------------------------------------
// stripe_lane_scheduler
//
// Sequences a serial byte stream across four striping lanes. Each accepted
// byte goes to the next enabled lane in round-robin order. Per-lane
// backpressure is honoured. A flush closes a partial group by writing
// PAD_BYTE to the remaining enabled lanes.
//
// Handshake: a byte transfers on a rising clk1Mhz edge when inVLD && inReady.
// inReady is combinational and depends only on the FSM state and on
// laneReady[ptr]. It never depends on inVLD.
//
// Ports
//   clk1Mhz     in   byte clock, rising edge
//   reset       in   asynchronous active-low reset
//   laneEnable  in   [3:0] lane mask, sampled only while IDLE
//   inVLD       in   input byte valid
//   inData      in   [7:0] input byte
//   flush       in   close current group (pad unwritten enabled lanes)
//   laneReady   in   [3:0] per-lane ready
//   inReady     out  input ready (combinational)
//   laneVLD     out  [3:0] registered one-hot lane write strobe
//   laneData    out  [7:0] registered byte for the strobed lane
//   laneSel     out  [1:0] registered index of the strobed lane
//   groupVLD    out  registered pulse with the write to the last lane of a group
//   cfgError    out  sticky: inVLD seen in IDLE with an empty lane mask
//   dbgState    out  [1:0] current FSM state (IDLE=0, STRIPE=1, PAD=2)
// -----------------------------------------------------------------------------
module stripe_lane_scheduler #(
  parameter logic [7:0] PAD_BYTE = 8'hF7
) (
  input  logic       clk1Mhz,
  input  logic       reset,
  input  logic [3:0] laneEnable,
  input  logic       inVLD,
  input  logic [7:0] inData,
  input  logic       flush,
  input  logic [3:0] laneReady,
  output logic       inReady,
  output logic [3:0] laneVLD,
  output logic [7:0] laneData,
  output logic [1:0] laneSel,
  output logic       groupVLD,
  output logic       cfgError,
  output logic [1:0] dbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRIPE = 2'd1,
    PAD    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] ptr_q, ptr_d;
  logic       cfg_err_q, cfg_err_d;
  logic [3:0] lane_vld_q;
  logic [7:0] lane_data_q;
  logic [1:0] lane_sel_q;
  logic       group_vld_q;

  logic       wr;
  logic [7:0] wr_data;
  logic       grp;
  logic       in_ready;
  logic [1:0] first_lane;
  logic [1:0] last_lane;
  logic [1:0] next_lane;
  logic [1:0] ptr_adv;

  // Lowest set bit; 0 for an empty mask.
  function automatic logic [1:0] first_of(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = i[1:0];
    end
    return r;
  endfunction

  // Highest set bit; 0 for an empty mask.
  function automatic logic [1:0] last_of(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = i[1:0];
    end
    return r;
  endfunction

  // Next set bit strictly above p, wrapping to the lowest set bit.
  function automatic logic [1:0] next_of(input logic [3:0] m, input logic [1:0] p);
    logic [1:0] r;
    r = first_of(m);
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(p))) r = i[1:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    cfg_err_d  = cfg_err_q;
    wr         = 1'b0;
    wr_data    = inData;
    grp        = 1'b0;
    in_ready   = 1'b0;
    first_lane = first_of(mask_q);
    last_lane  = last_of(mask_q);
    next_lane  = next_of(mask_q, ptr_q);
    ptr_adv    = ptr_q;

    case (state_q)
      IDLE: begin
        // Track the mask continuously so the group starts from whatever
        // mask was present on the cycle inVLD was first seen.
        mask_d = laneEnable;
        ptr_d  = first_of(laneEnable);
        if (inVLD) begin
          if (laneEnable != 4'd0) state_d = STRIPE;
          else                    cfg_err_d = 1'b1;
        end
      end
      STRIPE: begin
        in_ready = laneReady[ptr_q];
        if (inVLD && in_ready) begin
          wr      = 1'b1;
          grp     = (ptr_q == last_lane);
          ptr_adv = next_lane;
        end
        ptr_d = ptr_adv;
        // Boundary test uses the pointer after any same-cycle transfer.
        if (flush) begin
          state_d = (ptr_adv == first_lane) ? IDLE : PAD;
        end
      end
      PAD: begin
        if (laneReady[ptr_q]) begin
          wr      = 1'b1;
          wr_data = PAD_BYTE;
          grp     = (ptr_q == last_lane);
          ptr_d   = next_lane;
          if (ptr_q == last_lane) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mask_q      <= 4'd0;
      ptr_q       <= 2'd0;
      cfg_err_q   <= 1'b0;
      lane_vld_q  <= 4'd0;
      lane_data_q <= 8'd0;
      lane_sel_q  <= 2'd0;
      group_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      cfg_err_q   <= cfg_err_d;
      lane_vld_q  <= wr ? (4'b0001 << ptr_q) : 4'd0;
      group_vld_q <= grp;
      // Data and select hold their last value between writes.
      if (wr) begin
        lane_data_q <= wr_data;
        lane_sel_q  <= ptr_q;
      end
    end
  end

  assign inReady  = in_ready;
  assign laneVLD  = lane_vld_q;
  assign laneData = lane_data_q;
  assign laneSel  = lane_sel_q;
  assign groupVLD = group_vld_q;
  assign cfgError = cfg_err_q;
  assign dbgState = state_q;

endmodule

// File: doc/stripe_lane_scheduler.md
# stripe_lane_scheduler

Controller that sequences the byte-striping datapath across four lanes. It accepts a serial byte stream, assigns each byte to the next enabled lane in round-robin order, honours per-lane backpressure, and closes partial groups with pad bytes on flush. It sits directly upstream of the per-lane striping registers and drives their per-lane write strobes, lane select and group-complete signal.

## Interface
- PAD_BYTE, 8'hF7, byte written to remaining lanes when a partial group is flushed

- clk1Mhz  in  1  byte clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- laneEnable  in  4  lane mask (bit n = lane n in use); sampled only in IDLE
- inVLD  in  1  input byte valid
- inData  in  8  input byte
- flush  in  1  close the current group; pad any unwritten enabled lanes
- laneReady  in  4  per-lane ready; lane n accepts a write only when bit n = 1
- inReady  out  1  combinational; byte accepted on a cycle with inVLD && inReady
- laneVLD  out  4  registered one-hot write strobe to the target lane
- laneData  out  8  registered byte for the strobed lane
- laneSel  out  2  registered index of the strobed lane
- groupVLD  out  1  registered one-cycle pulse, asserted with the write to the last enabled lane of a group
- cfgError  out  1  sticky; set when inVLD arrives in IDLE with laneEnable == 0

## Operation
- Internal state: FSM {IDLE, STRIPE, PAD}, activeMask[3:0], ptr[1:0].
- first = lowest set bit of activeMask. last = highest set bit. next(ptr) = next set bit above ptr, wrapping to first.
- IDLE: activeMask <= laneEnable every cycle; ptr <= lowest set bit of laneEnable; inReady = 0.
  - inVLD && laneEnable != 0 -> STRIPE. No transfer in this cycle.
  - inVLD && laneEnable == 0 -> stay in IDLE; cfgError <= 1.
- STRIPE: inReady = laneReady[ptr]. A transfer writes inData to lane ptr, then ptr <= next(ptr). groupVLD is asserted when ptr == last.
  - flush with ptr == first (group boundary, after any same-cycle transfer) -> IDLE.
  - flush with ptr != first -> PAD.
  - A same-cycle transfer and flush are both honoured: the transfer first, then the boundary test uses the updated ptr.
  - A flush seen while no transfer is possible (laneReady[ptr] = 0) is acted on immediately using the current ptr.
- PAD: inReady = 0. When laneReady[ptr], writes PAD_BYTE to lane ptr and advances ptr. On the write to lane last, asserts groupVLD and goes to IDLE.
- The flush level is ignored in PAD and IDLE.
- activeMask never changes outside IDLE. laneEnable changes mid-group have no effect until the next IDLE.
- Single-lane mask: first == last, so every write is a group end and flush always goes straight to IDLE.
- cfgError is cleared only by reset.

## Timing
- Reset (reset = 0, asynchronous):
  - Outputs: laneVLD = 0, laneData = 0, laneSel = 0, groupVLD = 0, cfgError = 0, inReady = 0.
  - Internal: state = IDLE, activeMask = 0, ptr = 0.
- Reset asserted mid-group drops the partial group. No pad bytes and no groupVLD are produced.
- Latency is 1 cycle: a transfer or pad write in cycle t gives laneVLD/laneData/laneSel (and groupVLD if it applies) in cycle t+1.
- laneVLD is 0 in any cycle following a cycle with no write.
- IDLE -> STRIPE costs one cycle. The first byte can be accepted in the cycle after inVLD is first seen in IDLE.
- Throughput is 1 byte/cycle while laneReady[ptr] stays high.
- PAD takes one cycle per remaining enabled lane when the lanes are ready.

## Test plan
- laneEnable = 4'hF, laneReady = 4'hF, bytes 0x10..0x17 streamed: laneSel sequence is 0,1,2,3,0,1,2,3; laneData is 0x10..0x17; groupVLD pulses with 0x13 and with 0x17.
- laneEnable = 4'b1010, bytes 0xA0..0xA3: writes go to lanes 1,3,1,3; groupVLD pulses with 0xA1 and 0xA3; laneVLD[0] and laneVLD[2] never assert.
- laneEnable = 4'hF; send 0x01, 0x02, then flush: lanes 2 and 3 receive 0xF7 on consecutive cycles; groupVLD pulses with lane 3; FSM returns to IDLE.
- laneReady[2] held low for 3 cycles mid-group: inReady = 0 for those 3 cycles; no write occurs; byte order is preserved once laneReady[2] rises.
- laneEnable = 0 with inVLD = 1: inReady stays 0, cfgError sets and stays 1. Change laneEnable to 4'h1 and send 4 bytes: all 4 go to lane 0, each with groupVLD.
- reset pulsed low after 2 of 4 bytes: all outputs return to 0 immediately. The next stream starts at lane first, with no pad and no groupVLD from the aborted group.
